// File: rtl/audio_fifo_ctl.sv
// rtl/audio_fifo_ctl.sv - FWFT audio sample FIFO with thresholds, sticky errors, flush and overwrite mode
module audio_fifo_ctl #(
    parameter int DATA      = 24,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int OVERWRITE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic                         read,
    input  logic                         flush,
    input  logic                         clear_err,
    input  logic [DATA-1:0]              wdata,
    output logic [DATA-1:0]              rdata,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            rd_acc;
    logic            wr_acc;
    logic            lost;
    logic            drop;
    logic            inc;
    logic            dec;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_LEVEL);
    assign almost_empty = (int'(count) <= AE_LEVEL);
    assign rdata        = empty ? '0 : mem[rd_ptr];

    assign rd_acc = read & ~empty;
    assign wr_acc = (OVERWRITE != 0) ? write : (write & (~full | rd_acc));
    // A write into a full FIFO with no pop loses a sample: either the new one or the oldest.
    assign lost   = write & full & ~rd_acc;
    assign drop   = lost & (OVERWRITE != 0);
    assign inc    = wr_acc & ~rd_acc & ~full;
    assign dec    = rd_acc & ~wr_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= nxt(wr_ptr);
            if (rd_acc | drop)
                rd_ptr <= nxt(rd_ptr);
            if (inc)
                count <= count + 1'b1;
            else if (dec)
                count <= count - 1'b1;
            overflow  <= lost | (overflow & ~clear_err);
            underflow <= (read & empty) | (underflow & ~clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc & ~flush & ~reset)
            mem[wr_ptr] <= wdata;
    end
endmodule

// File: tb/tb_audio_fifo_ctl.sv
// tb/tb_audio_fifo_ctl.sv - scoreboard bench for audio_fifo_ctl, reject and overwrite variants side by side
module tb_audio_fifo_ctl;
    localparam int DATA = 16;
    localparam int DEPTH = 10;
    localparam int AF = 8;
    localparam int AE = 2;

    typedef struct {
        int rdata;
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit of;
        bit uf;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    logic write = 0, read = 0, flush = 0, clear_err = 0;
    logic [DATA-1:0] wdata = '0;

    logic [DATA-1:0] rd0, rd1;
    logic f0, f1, e0, e1, af0, af1, ae0, ae1, of0, of1, uf0, uf1;
    logic [3:0] c0, c1;

    int tests = 0;
    int fails = 0;

    logic [DATA-1:0] mq [2][$];
    bit mof [2];
    bit muf [2];
    exp_t sb0 [$];
    exp_t sb1 [$];

    audio_fifo_ctl #(.DATA(DATA), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .OVERWRITE(0)) u0 (
        .clk(clk), .reset(reset), .write(write), .read(read), .flush(flush), .clear_err(clear_err),
        .wdata(wdata), .rdata(rd0), .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
        .count(c0), .overflow(of0), .underflow(uf0));

    audio_fifo_ctl #(.DATA(DATA), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .OVERWRITE(1)) u1 (
        .clk(clk), .reset(reset), .write(write), .read(read), .flush(flush), .clear_err(clear_err),
        .wdata(wdata), .rdata(rd1), .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
        .count(c1), .overflow(of1), .underflow(uf1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s ovw=%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input int k, input exp_t e);
        if (k == 0) begin
            chk("rdata", 0, int'(rd0), e.rdata); chk("count", 0, int'(c0), e.cnt);
            chk("full", 0, int'(f0), int'(e.full)); chk("empty", 0, int'(e0), int'(e.empty));
            chk("almost_full", 0, int'(af0), int'(e.af)); chk("almost_empty", 0, int'(ae0), int'(e.ae));
            chk("overflow", 0, int'(of0), int'(e.of)); chk("underflow", 0, int'(uf0), int'(e.uf));
        end else begin
            chk("rdata", 1, int'(rd1), e.rdata); chk("count", 1, int'(c1), e.cnt);
            chk("full", 1, int'(f1), int'(e.full)); chk("empty", 1, int'(e1), int'(e.empty));
            chk("almost_full", 1, int'(af1), int'(e.af)); chk("almost_empty", 1, int'(ae1), int'(e.ae));
            chk("overflow", 1, int'(of1), int'(e.of)); chk("underflow", 1, int'(uf1), int'(e.uf));
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        int n = mq[k].size();
        e.rdata = (n > 0) ? int'(mq[k][0]) : 0;
        e.cnt   = n;
        e.full  = (n == DEPTH);
        e.empty = (n == 0);
        e.af    = (n >= AF);
        e.ae    = (n <= AE);
        e.of    = mof[k];
        e.uf    = muf[k];
        return e;
    endfunction

    // Queue-level behaviour: a pop frees room for a same-cycle push; overwrite mode evicts the oldest.
    task automatic model(input int k);
        bit popped;
        if (reset) begin
            mq[k].delete(); mof[k] = 0; muf[k] = 0;
        end else if (flush) begin
            mq[k].delete();
        end else begin
            if (clear_err) begin mof[k] = 0; muf[k] = 0; end
            popped = 0;
            if (read) begin
                if (mq[k].size() == 0) muf[k] = 1;
                else begin void'(mq[k].pop_front()); popped = 1; end
            end
            if (write) begin
                if (mq[k].size() < DEPTH) mq[k].push_back(wdata);
                else begin
                    mof[k] = 1;
                    if (k == 1) begin void'(mq[k].pop_front()); mq[k].push_back(wdata); end
                end
            end
            if (popped && !read) mof[k] = mof[k];
        end
    endtask

    task automatic step(input bit w, input bit r, input bit f, input bit c, input int d);
        @(negedge clk); #1;
        write = w; read = r; flush = f; clear_err = c; wdata = DATA'(d);
        @(posedge clk);
        model(0); model(1);
        sb0.push_back(expect_of(0));
        sb1.push_back(expect_of(1));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb0.size() > 0) cmp_all(0, sb0.pop_front());
            if (sb1.size() > 0) cmp_all(1, sb1.pop_front());
        end
    end

    initial begin
        #1;
        chk("reset_count", 0, int'(c0), 0); chk("reset_empty", 0, int'(e0), 1);
        chk("reset_full", 0, int'(f0), 0); chk("reset_ae", 0, int'(ae0), 1);
        chk("reset_af", 0, int'(af0), 0); chk("reset_rdata", 0, int'(rd0), 0);
        chk("reset_flags", 1, int'({of1, uf1}), 0); chk("reset_count", 1, int'(c1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;

        // fill, then write into full; reject vs overwrite diverge here
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, i);
        step(1, 0, 0, 0, 99);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);

        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, i);
        for (int i = 10; i < 20; i++) step(1, 0, 0, 0, i);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);

        // wrap with simultaneous traffic at full
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, i);
        for (int i = 10; i < 20; i++) step(1, 1, 0, 0, i);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);

        // empty-side boundaries and clear_err precedence
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 7);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);

        // flush overrides write; then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 40 + i);
        step(1, 0, 1, 0, 123);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 60 + i);
        @(negedge clk); #1;
        write = 0; read = 0; flush = 0; clear_err = 0;
        reset = 1;
        #1;
        chk("async_reset_count", 0, int'(c0), 0); chk("async_reset_empty", 0, int'(e0), 1);
        chk("async_reset_count", 1, int'(c1), 0); chk("async_reset_empty", 1, int'(e1), 1);
        @(posedge clk);
        model(0); model(1);
        sb0.push_back(expect_of(0)); sb1.push_back(expect_of(1));
        @(negedge clk); #1; reset = 0;

        for (int i = 0; i < 1500; i++) begin
            bit w, r, f, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 99) < 3);
            c = !f && ($urandom_range(0, 99) < 5);
            step(w, r, f, c, int'($urandom_range(0, 65535)));
        end

        for (int i = 0; i < 10 && (sb0.size() > 0 || sb1.size() > 0); i++) @(negedge clk);
        chk("scoreboard_drained", 0, sb0.size() + sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
